fetch_decode_ctrl: RTL and testbench

Multi-cycle fetch/decode/sequencing stage directly upstream of the 8-bit ALU.
- Holds the PC and fetches 8-bit instructions from a synchronous-read instruction memory.
- Decodes the 5-bit opcode and register fields, and drives the ALU opcode and operand selects into the register file.
- Owns the condition bit (CB), branches, load/store handshake and halt.

---
 rtl/cpu_pkg.sv | 64 ++++++
 rtl/instr_decoder.sv | 82 ++++++++
 rtl/fetch_decode_ctrl.sv | 118 +++++++++++
 tb/tb_fetch_decode_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode stage and the ALU: opcodes, FSM states,
// write-back source encodings and the decoded-instruction payload.
package cpu_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned IMM_W   = 8;

  // Prefix patterns: AND/ADD carry rd in the low opcode bits, SET carries its immediate.
  localparam logic [1:0] OP_AND_PFX = 2'b00;
  localparam logic [1:0] OP_ADD_PFX = 2'b01;
  localparam logic [2:0] OP_SET_PFX = 3'b110;

  localparam logic [OP_W-1:0] OP_SLT     = 5'b10000;
  localparam logic [OP_W-1:0] OP_HALT    = 5'b10001;
  localparam logic [OP_W-1:0] OP_LOAD    = 5'b10010;
  localparam logic [OP_W-1:0] OP_STORE   = 5'b10011;
  localparam logic [OP_W-1:0] OP_ABS     = 5'b10100;
  localparam logic [OP_W-1:0] OP_SEQ     = 5'b10101;
  localparam logic [OP_W-1:0] OP_BRANCHB = 5'b10110;
  localparam logic [OP_W-1:0] OP_NOP     = 5'b10111;
  localparam logic [OP_W-1:0] OP_SLL     = 5'b11100;
  localparam logic [OP_W-1:0] OP_SRL     = 5'b11101;
  localparam logic [OP_W-1:0] OP_BRANCH  = 5'b11110;
  localparam logic [OP_W-1:0] OP_SUB     = 5'b11111;

  localparam logic [REG_W-1:0] REG_R2 = 3'd2;
  localparam logic [REG_W-1:0] REG_R5 = 3'd5;
  localparam logic [REG_W-1:0] REG_R6 = 3'd6;
  localparam logic [REG_W-1:0] REG_R7 = 3'd7;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_IMM = 2'd1,
    WB_MEM = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    wb_src_e          wb_src;
    logic             is_branch;
    logic             is_branchb;
    logic             is_mem;
    logic             is_store;
    logic             is_cmp;
    logic             is_halt;
    logic             writes_reg;
  } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decode: instruction word to register selects,
// immediate, write-back source and instruction class flags.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output dec_t               dec_o
);

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] r_lo;

  assign op   = instr_i[7:3];
  assign r_lo = instr_i[2:0];

  always_comb begin
    dec_o        = '0;
    dec_o.opcode = op;
    dec_o.imm    = {3'b000, instr_i[4:0]};
    dec_o.wb_src = WB_ALU;

    if (instr_i[7:6] == OP_AND_PFX || instr_i[7:6] == OP_ADD_PFX) begin
      dec_o.rd         = instr_i[5:3];
      dec_o.rs         = r_lo;
      dec_o.rt         = REG_R7;
      dec_o.writes_reg = 1'b1;
    end else if (instr_i[7:5] == OP_SET_PFX) begin
      dec_o.rd         = REG_R7;
      dec_o.wb_src     = WB_IMM;
      dec_o.writes_reg = 1'b1;
    end else begin
      case (op)
        OP_SLL, OP_SRL, OP_ABS: begin
          dec_o.rd         = r_lo;
          dec_o.rs         = r_lo;
          dec_o.rt         = REG_R7;
          dec_o.writes_reg = 1'b1;
        end
        OP_SUB: begin
          dec_o.rs         = REG_R2;
          dec_o.rt         = REG_R5;
          dec_o.rd         = r_lo;
          dec_o.writes_reg = 1'b1;
        end
        OP_SLT: begin
          dec_o.rs     = REG_R6;
          dec_o.rt     = REG_R7;
          dec_o.is_cmp = 1'b1;
        end
        OP_SEQ: begin
          dec_o.rs     = r_lo;
          dec_o.rt     = REG_R7;
          dec_o.is_cmp = 1'b1;
        end
        OP_BRANCH: begin
          dec_o.rs        = r_lo;
          dec_o.is_branch = 1'b1;
        end
        OP_BRANCHB: begin
          dec_o.rs         = r_lo;
          dec_o.is_branchb = 1'b1;
        end
        OP_LOAD: begin
          dec_o.rs         = REG_R7;
          dec_o.rd         = r_lo;
          dec_o.wb_src     = WB_MEM;
          dec_o.is_mem     = 1'b1;
          dec_o.writes_reg = 1'b1;
        end
        OP_STORE: begin
          dec_o.rs       = REG_R7;
          dec_o.rt       = r_lo;
          dec_o.is_mem   = 1'b1;
          dec_o.is_store = 1'b1;
        end
        OP_HALT: dec_o.is_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/sequencing stage feeding the 8-bit ALU: owns PC,
// condition bit, branches, the load/store handshake and halt.
module fetch_decode_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned         PC_W     = 8,
  parameter logic [PC_W-1:0]     RESET_PC = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic [PC_W-1:0]      imem_addr_o,
  input  logic [INSTR_W-1:0]   imem_data_i,
  output logic [OP_W-1:0]      opcode_o,
  output logic [REG_W-1:0]     rs_sel_o,
  output logic [REG_W-1:0]     rt_sel_o,
  output logic [REG_W-1:0]     rd_sel_o,
  output logic [IMM_W-1:0]     imm_o,
  output logic [1:0]           wb_src_o,
  output logic                 reg_we_o,
  input  logic [7:0]           rs_data_i,
  input  logic                 set_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  input  logic                 mem_ready_i,
  output logic                 cb_o,
  output logic                 halted_o
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            cb_q, cb_d;
  dec_t            dec_q, dec_d;
  dec_t            dec_c;
  logic            reg_we_q, reg_we_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic            halted_q, halted_d;

  instr_decoder u_dec (
    .instr_i (imem_data_i),
    .dec_o   (dec_c)
  );

  // Sequencing, PC/CB update and registered enables (derived from the next state).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cb_d    = cb_q;
    dec_d   = dec_q;

    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        dec_d   = dec_c;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        if (dec_q.is_halt)     state_d = HALT;
        else if (dec_q.is_mem) state_d = MEM;
        else                   state_d = WRITEBACK;
      end
      MEM: begin
        if (mem_ready_i) state_d = WRITEBACK;
      end
      WRITEBACK: begin
        state_d = FETCH;
        if (dec_q.is_cmp) cb_d = set_i;
        // Taken-branch decision uses CB as it stood on entry to this state.
        if (dec_q.is_branch && cb_q)       pc_d = rs_data_i[PC_W-1:0];
        else if (dec_q.is_branchb && cb_q) pc_d = pc_q - rs_data_i[PC_W-1:0];
        else                               pc_d = pc_q + PC_W'(1);
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

    reg_we_d  = (state_d == WRITEBACK) && dec_d.writes_reg;
    mem_req_d = (state_d == MEM);
    mem_we_d  = (state_d == MEM) && dec_d.is_store;
    halted_d  = (state_d == HALT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      cb_q      <= 1'b0;
      dec_q     <= '0;
      reg_we_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cb_q      <= cb_d;
      dec_q     <= dec_d;
      reg_we_q  <= reg_we_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      halted_q  <= halted_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign opcode_o    = dec_q.opcode;
  assign rs_sel_o    = dec_q.rs;
  assign rt_sel_o    = dec_q.rt;
  assign rd_sel_o    = dec_q.rd;
  assign imm_o       = dec_q.imm;
  assign wb_src_o    = dec_q.wb_src;
  assign reg_we_o    = reg_we_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign cb_o        = cb_q;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: an instruction-level model predicts every
// output each cycle; a negedge process compares, literal checks pin the model.
module tb_fetch_decode_ctrl;

  logic       clk;
  logic       rst_i;
  logic [7:0] imem_addr_o;
  logic [7:0] imem_data_i;
  logic [4:0] opcode_o;
  logic [2:0] rs_sel_o, rt_sel_o, rd_sel_o;
  logic [7:0] imm_o;
  logic [1:0] wb_src_o;
  logic       reg_we_o;
  logic [7:0] rs_data_i;
  logic       set_i;
  logic       mem_req_o, mem_we_o, mem_ready_i;
  logic       cb_o, halted_o;

  fetch_decode_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .imem_addr_o (imem_addr_o),
    .imem_data_i (imem_data_i),
    .opcode_o    (opcode_o),
    .rs_sel_o    (rs_sel_o),
    .rt_sel_o    (rt_sel_o),
    .rd_sel_o    (rd_sel_o),
    .imm_o       (imm_o),
    .wb_src_o    (wb_src_o),
    .reg_we_o    (reg_we_o),
    .rs_data_i   (rs_data_i),
    .set_i       (set_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_ready_i (mem_ready_i),
    .cb_o        (cb_o),
    .halted_o    (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] rs, rt, rd;
    logic       rs_c, rt_c, rd_c, imm_c, we;
    logic [1:0] wb;
    logic       mem, st, cmp, br, brb, halt;
  } exp_t;

  int n_chk = 0;
  int n_fail = 0;

  // Architectural model state
  logic [7:0] m_pc = 8'h00;
  logic       m_cb = 1'b0;
  logic       m_halted = 1'b0;

  // Per-cycle expectations
  logic       chk_en = 1'b0, x_rst = 1'b0, x_sel = 1'b0, x_exec = 1'b0;
  logic [7:0] x_addr = 8'h00, x_imm = 8'h00;
  logic [4:0] x_op = 5'h0;
  logic       x_reg_we = 1'b0, x_mem_req = 1'b0, x_mem_we = 1'b0, x_halted = 1'b0, x_cb = 1'b0;
  exp_t       x_e = '0;

  logic [4:0] cap_op;
  logic [2:0] cap_rs, cap_rd;
  logic [7:0] cap_imm;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t, model pc 0x%0h)", nm, act, exp, $time, m_pc);
    end
  endtask

  // Instruction semantics straight from the ISA table.
  function automatic exp_t mdl(input logic [7:0] ir);
    exp_t       e;
    logic [4:0] op;
    logic [2:0] r;
    e  = '0;
    op = ir[7:3];
    r  = ir[2:0];
    if (!ir[7]) begin
      e.rd = ir[5:3]; e.rs = r; e.rt = 3'd7;
      e.rs_c = 1; e.rt_c = 1; e.rd_c = 1; e.we = 1;
    end else if (ir[7:5] == 3'b110) begin
      e.rd = 3'd7; e.rd_c = 1; e.imm_c = 1; e.we = 1; e.wb = 2'd1;
    end else begin
      case (op)
        5'b11100, 5'b11101, 5'b10100: begin
          e.rd = r; e.rs = r; e.rt = 3'd7;
          e.rs_c = 1; e.rt_c = 1; e.rd_c = 1; e.we = 1;
        end
        5'b11111: begin
          e.rs = 3'd2; e.rt = 3'd5; e.rd = r;
          e.rs_c = 1; e.rt_c = 1; e.rd_c = 1; e.we = 1;
        end
        5'b10000: begin e.rs = 3'd6; e.rt = 3'd7; e.rs_c = 1; e.rt_c = 1; e.cmp = 1; end
        5'b10101: begin e.rs = r;    e.rt = 3'd7; e.rs_c = 1; e.rt_c = 1; e.cmp = 1; end
        5'b11110: begin e.rs = r; e.rs_c = 1; e.br = 1; end
        5'b10110: begin e.rs = r; e.rs_c = 1; e.brb = 1; end
        5'b10010: begin
          e.rs = 3'd7; e.rd = r; e.rs_c = 1; e.rd_c = 1; e.we = 1; e.wb = 2'd2; e.mem = 1;
        end
        5'b10011: begin e.rs = 3'd7; e.rt = r; e.rs_c = 1; e.rt_c = 1; e.mem = 1; e.st = 1; end
        5'b10001: e.halt = 1;
        default: ;
      endcase
    end
    return e;
  endfunction

  // Compare DUT against the current expectations mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", 32'(imem_addr_o), 32'(x_addr));
      chk("reg_we", 32'(reg_we_o), 32'(x_reg_we));
      chk("mem_req", 32'(mem_req_o), 32'(x_mem_req));
      if (x_mem_req) chk("mem_we", 32'(mem_we_o), 32'(x_mem_we));
      chk("halted", 32'(halted_o), 32'(x_halted));
      chk("cb", 32'(cb_o), 32'(x_cb));
      if (x_rst)
        chk("reset_fields", 32'({opcode_o, rs_sel_o, rt_sel_o, rd_sel_o, imm_o, wb_src_o}), 32'd0);
      if (x_sel) begin
        chk("opcode", 32'(opcode_o), 32'(x_op));
        if (x_e.rs_c)  chk("rs_sel", 32'(rs_sel_o), 32'(x_e.rs));
        if (x_e.rt_c)  chk("rt_sel", 32'(rt_sel_o), 32'(x_e.rt));
        if (x_e.rd_c)  chk("rd_sel", 32'(rd_sel_o), 32'(x_e.rd));
        if (x_e.imm_c) chk("imm", 32'(imm_o), 32'(x_imm));
      end
      if (x_reg_we) chk("wb_src", 32'(wb_src_o), 32'(x_e.wb));
      if (x_exec) begin
        cap_op  = opcode_o;
        cap_rs  = rs_sel_o;
        cap_rd  = rd_sel_o;
        cap_imm = imm_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic base_exp();
    x_rst = 0; x_sel = 0; x_exec = 0;
    x_addr = m_pc; x_reg_we = 0; x_mem_req = 0; x_mem_we = 0;
    x_halted = m_halted; x_cb = m_cb;
  endtask

  // Entered in a FETCH cycle; returns in the next FETCH cycle (or first HALT cycle).
  task automatic run(input logic [7:0] ir, input logic setv, input logic [7:0] rsd,
                     input int mwait, input int rst_at);
    exp_t e;
    e = mdl(ir);
    base_exp();
    imem_data_i = ~ir; set_i = setv; rs_data_i = rsd; mem_ready_i = 1'b1;
    tick();
    imem_data_i = ir;
    tick();
    imem_data_i = ~ir;
    x_e = e; x_op = ir[7:3]; x_imm = {3'b000, ir[4:0]}; x_sel = 1; x_exec = 1;
    tick();
    x_exec = 0;
    if (e.halt) begin
      m_halted = 1'b1;
      base_exp();
      return;
    end
    if (e.mem) begin
      for (int i = 1; i <= mwait; i++) begin
        x_mem_req = 1; x_mem_we = e.st; mem_ready_i = (i == mwait);
        if (i == rst_at) begin
          rst_i = 1'b1;
          tick();
          m_pc = 8'h00; m_cb = 1'b0;
          base_exp();
          x_rst = 1'b1;
          @(negedge clk);
          #1;
          rst_i = 1'b0;
          x_rst = 1'b0;
          return;
        end
        tick();
      end
      x_mem_req = 0; x_mem_we = 0; mem_ready_i = 1'b1;
    end
    x_reg_we = e.we;
    tick();
    if (e.cmp) m_cb = setv;
    if (e.br && m_cb)       m_pc = rsd;
    else if (e.brb && m_cb) m_pc = m_pc - rsd;
    else                    m_pc = m_pc + 8'd1;
    base_exp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] alu_ops [7];

  initial begin
    alu_ops = '{8'h3A, 8'hFC, 8'hE5, 8'hEE, 8'hA1, 8'hC3, 8'hBB};
    rst_i = 1'b1; imem_data_i = 8'h00; rs_data_i = 8'h00; set_i = 1'b0; mem_ready_i = 1'b0;
    tick();
    tick();
    base_exp();
    x_rst = 1'b1;
    chk_en = 1'b1;
    tick();
    rst_i = 1'b0;

    // ADD r1 <- r3 + r7
    run(8'h4B, 1'b0, 8'h00, 0, 0);
    chk("add_opcode_lit", 32'(cap_op), 32'h09);
    chk("add_rs_lit", 32'(cap_rs), 32'd3);
    chk("add_pc_lit", 32'(imem_addr_o), 32'h01);

    // SET r7 <- 0x15
    run(8'hD5, 1'b0, 8'h00, 0, 0);
    chk("set_imm_lit", 32'(cap_imm), 32'h15);
    chk("set_rd_lit", 32'(cap_rd), 32'd7);

    for (int i = 0; i < 7; i++) run(alu_ops[i], 1'b1, 8'hAA, 0, 0);
    chk("alu_seq_pc_lit", 32'(imem_addr_o), 32'h09);

    // Compare then taken / not-taken branch
    run(8'hA9, 1'b1, 8'h00, 0, 0);
    run(8'hF2, 1'b0, 8'h40, 0, 0);
    chk("br_taken_lit", 32'(imem_addr_o), 32'h40);
    run(8'hA9, 1'b0, 8'h00, 0, 0);
    chk("cb_clear_lit", 32'(cb_o), 32'd0);
    run(8'hF2, 1'b1, 8'h40, 0, 0);
    chk("br_not_taken_lit", 32'(imem_addr_o), 32'h42);

    // SLT sets CB, branch to 0x02, BRANCHB 2 - 5 wraps to 0xFD
    run(8'h80, 1'b1, 8'h00, 0, 0);
    run(8'hF2, 1'b0, 8'h02, 0, 0);
    run(8'hB3, 1'b0, 8'h05, 0, 0);
    chk("brb_wrap_lit", 32'(imem_addr_o), 32'hFD);
    for (int i = 0; i < 3; i++) run(8'hB8, 1'b0, 8'h00, 0, 0);
    chk("pc_inc_wrap_lit", 32'(imem_addr_o), 32'h00);

    // Load with 3 wait cycles, store with immediate ready
    run(8'h96, 1'b0, 8'h00, 3, 0);
    chk("load_rd_lit", 32'(cap_rd), 32'd6);
    run(8'h99, 1'b0, 8'h00, 1, 0);
    chk("store_pc_lit", 32'(imem_addr_o), 32'h02);

    // Reset in the middle of a load's MEM phase
    run(8'h92, 1'b0, 8'h00, 4, 2);
    chk("rst_mem_req_lit", 32'(mem_req_o), 32'd0);
    chk("rst_pc_lit", 32'(imem_addr_o), 32'h00);
    chk("rst_cb_lit", 32'(cb_o), 32'd0);

    // Reach PC 0x07 and halt
    run(8'h80, 1'b1, 8'h00, 0, 0);
    run(8'hF2, 1'b0, 8'h07, 0, 0);
    run(8'h88, 1'b0, 8'h00, 0, 0);
    for (int i = 0; i < 20; i++) begin
      imem_data_i = 8'($urandom);
      mem_ready_i = 1'($urandom);
      tick();
    end
    chk("halt_pc_lit", 32'(imem_addr_o), 32'h07);
    chk("halt_flag_lit", 32'(halted_o), 32'd1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
